quad_enc_counter: RTL

//  Quadrature encoder front end for the SPI stepper/IO controller. Synchronises and

---
 rtl/quad_enc_counter_pkg.sv | 46 ++++
 rtl/quad_enc_counter_enc_filter.sv | 73 +++++++
 rtl/quad_enc_counter.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/quad_enc_counter_pkg.sv
// Shared definitions for the quadrature encoder counter.
//   - qenc_step_e : decoded step code for one clock of filtered A/B movement
//   - QENC_W_DEF / QENC_FILT_DEF : default count width and filter depth
//   - qenc_decode : Gray-code step decoder (previous {A,B} vs current {A,B})
package quad_enc_counter_pkg;

    localparam int QENC_W_DEF    = 16;
    localparam int QENC_FILT_DEF = 3;

    typedef enum logic [1:0] {
        QENC_HOLD = 2'b00,
        QENC_UP   = 2'b01,
        QENC_DN   = 2'b10,
        QENC_ERR  = 2'b11
    } qenc_step_e;

    // Forward sequence is 00 -> 01 -> 11 -> 10 -> 00 on {A,B}.
    function automatic logic [1:0] qenc_next_up(input logic [1:0] ab);
        logic [1:0] nxt;
        case (ab)
            2'b00:   nxt = 2'b01;
            2'b01:   nxt = 2'b11;
            2'b11:   nxt = 2'b10;
            2'b10:   nxt = 2'b00;
            default: nxt = 2'b00;
        endcase
        return nxt;
    endfunction

    // Both bits changing at once cannot be attributed to a direction.
    function automatic qenc_step_e qenc_decode(input logic [1:0] prev_ab,
                                               input logic [1:0] cur_ab);
        qenc_step_e step;
        if (prev_ab == cur_ab) begin
            step = QENC_HOLD;
        end else if ((prev_ab ^ cur_ab) == 2'b11) begin
            step = QENC_ERR;
        end else if (qenc_next_up(prev_ab) == cur_ab) begin
            step = QENC_UP;
        end else begin
            step = QENC_DN;
        end
        return step;
    endfunction

endpackage

// File: rtl/quad_enc_counter_enc_filter.sv
// enc_filter: two-flop synchroniser followed by a strobe-driven glitch filter
// for one asynchronous encoder input.
//   clk         in  system clock
//   rst_n       in  asynchronous active-low reset (filtered level restarts at 0)
//   sample_en_i in  1-cycle sample strobe
//   raw_i       in  raw asynchronous input
//   filt_o      out filtered level; changes only on sample_en_i strobes
// The filtered level flips on the FILT-th consecutive strobe at which the
// synchronised level differs from it; any agreeing strobe restarts the run.
module enc_filter #(
    parameter int FILT = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sample_en_i,
    input  logic raw_i,
    output logic filt_o
);

    localparam int CW = (FILT > 1) ? $clog2(FILT) : 1;

    logic          sync1_q;
    logic          sync2_q;
    logic          filt_q;
    logic          filt_d;
    logic [CW-1:0] run_q;
    logic [CW-1:0] run_d;

    // Synchroniser chain for the asynchronous input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
        end
    end

    // Run counter holds the number of earlier consecutive disagreeing strobes.
    always_comb begin
        filt_d = filt_q;
        run_d  = run_q;
        if (sample_en_i) begin
            if (sync2_q != filt_q) begin
                if (run_q == CW'(FILT - 1)) begin
                    filt_d = sync2_q;
                    run_d  = '0;
                end else begin
                    run_d  = run_q + CW'(1);
                end
            end else begin
                run_d = '0;
            end
        end else begin
            run_d = run_q;
        end
    end

    // Filter state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filt_q <= 1'b0;
            run_q  <= '0;
        end else begin
            filt_q <= filt_d;
            run_q  <= run_d;
        end
    end

    assign filt_o = filt_q;

endmodule

// File: rtl/quad_enc_counter.sv
// quad_enc_counter: quadrature encoder front end. Filters A/B/Z, decodes 4x
// quadrature into a wrapping live count, latches the count at index (Z) rising
// edges and exposes a snapshot of the live count taken on SPI frame start.
//   clk, rst_n   clock, asynchronous active-low reset
//   sample_en    filter sample strobe
//   enc_a/b/z    raw asynchronous encoder inputs
//   snapshot     copy live count to count
//   clear        zero live count and index_seen
//   err_clr      clear sticky err
//   index_arm    arm index reset (only with QENC_INDEX_RESET_EN)
//   count        snapshot of live count
//   index_pos    live count at last filtered Z rising edge
//   index_seen   sticky Z-seen flag
//   err          sticky illegal-transition flag
// Build option: define QENC_INDEX_RESET_EN to let an armed index edge zero the
// live count once.
module quad_enc_counter
    import quad_enc_counter_pkg::*;
#(
    parameter int W    = QENC_W_DEF,
    parameter int FILT = QENC_FILT_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         sample_en,
    input  logic         enc_a,
    input  logic         enc_b,
    input  logic         enc_z,
    input  logic         snapshot,
    input  logic         clear,
    input  logic         err_clr,
    input  logic         index_arm,
    output logic [W-1:0] count,
    output logic [W-1:0] index_pos,
    output logic         index_seen,
    output logic         err
);

    logic         a_filt_s;
    logic         b_filt_s;
    logic         z_filt_s;
    logic [1:0]   ab_s;
    qenc_step_e   step_s;
    logic         z_rise_s;

    logic [1:0]   prev_ab_q;
    logic         z_prev_q;
    logic [W-1:0] live_q;
    logic [W-1:0] live_d;
    logic [W-1:0] count_q;
    logic [W-1:0] count_d;
    logic [W-1:0] index_pos_q;
    logic [W-1:0] index_pos_d;
    logic         index_seen_q;
    logic         index_seen_d;
    logic         err_q;
    logic         err_d;

    enc_filter #(.FILT(FILT)) u_filt_a (
        .clk(clk), .rst_n(rst_n), .sample_en_i(sample_en), .raw_i(enc_a), .filt_o(a_filt_s)
    );
    enc_filter #(.FILT(FILT)) u_filt_b (
        .clk(clk), .rst_n(rst_n), .sample_en_i(sample_en), .raw_i(enc_b), .filt_o(b_filt_s)
    );
    enc_filter #(.FILT(FILT)) u_filt_z (
        .clk(clk), .rst_n(rst_n), .sample_en_i(sample_en), .raw_i(enc_z), .filt_o(z_filt_s)
    );

    assign ab_s     = {a_filt_s, b_filt_s};
    assign step_s   = qenc_decode(prev_ab_q, ab_s);
    assign z_rise_s = z_filt_s & ~z_prev_q;

`ifdef QENC_INDEX_RESET_EN
    logic armed_q;
    logic armed_d;
`else
    logic unused_index_arm_s;
    assign unused_index_arm_s = index_arm;
`endif

    // Next-state logic: step, index handling, snapshot and sticky flags.
    always_comb begin
        live_d       = live_q;
        count_d      = count_q;
        index_pos_d  = index_pos_q;
        index_seen_d = index_seen_q;
        err_d        = err_q;

        case (step_s)
            QENC_UP: live_d = live_q + W'(1);
            QENC_DN: live_d = live_q - W'(1);
            default: live_d = live_q;
        endcase

`ifdef QENC_INDEX_RESET_EN
        armed_d = armed_q;
        if (z_rise_s && armed_q) begin
            live_d  = '0;
            armed_d = 1'b0;
        end else if (index_arm) begin
            armed_d = 1'b1;
        end else begin
            armed_d = armed_q;
        end
`endif

        // index_pos takes the pre-step value of the live count.
        if (z_rise_s) begin
            index_pos_d  = live_q;
            index_seen_d = 1'b1;
        end else begin
            index_pos_d  = index_pos_q;
        end

        // clear has top priority over index reset and stepping.
        if (clear) begin
            live_d       = '0;
            index_seen_d = 1'b0;
        end else begin
            live_d       = live_d;
        end

        // A new illegal transition wins over err_clr.
        if (step_s == QENC_ERR) begin
            err_d = 1'b1;
        end else if (err_clr) begin
            err_d = 1'b0;
        end else begin
            err_d = err_q;
        end

        if (snapshot) begin
            count_d = live_q;
        end else begin
            count_d = count_q;
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_ab_q    <= 2'b00;
            z_prev_q     <= 1'b0;
            live_q       <= '0;
            count_q      <= '0;
            index_pos_q  <= '0;
            index_seen_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            prev_ab_q    <= ab_s;
            z_prev_q     <= z_filt_s;
            live_q       <= live_d;
            count_q      <= count_d;
            index_pos_q  <= index_pos_d;
            index_seen_q <= index_seen_d;
            err_q        <= err_d;
        end
    end

`ifdef QENC_INDEX_RESET_EN
    // Index-reset arming flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            armed_q <= 1'b0;
        end else begin
            armed_q <= armed_d;
        end
    end
`endif

    assign count      = count_q;
    assign index_pos  = index_pos_q;
    assign index_seen = index_seen_q;
    assign err        = err_q;

endmodule
